// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI target: FSM encoding, SPI mode encodings
// and bit order, kept in step with the spi_master side.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_e;

    // Mode encodings are {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam bit SPI_MSB_FIRST = 1'b1;

    function automatic logic [1:0] spi_mode(input int cpol, input int cpha);
        return {cpol[0], cpha[0]};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall pulses derived
// from the last two synchronized samples.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversamples SCLK/CS/MOSI in the clk domain, shifts one DATA_WIDTH word
// in from MOSI and one out on MISO per word, MSB first, in any of the four SPI modes.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  CS,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output state_e                state_dbg
);

    localparam int DW = DATA_WIDTH;
    localparam int BW = $clog2(DW);
    localparam logic [1:0]    MODE = spi_mode(CPOL, CPHA);
    localparam logic [BW-1:0] LAST = BW'(DW - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic mosi_s;

    // CS synchronizer resets low so WAIT_IDLE only exits once CS is really seen high
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(MODE[1])) u_sclk_sync (
        .clk(clk), .rst(rst), .din(SCLK), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk(clk), .rst(rst), .din(CS), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge & (sclk_s != MODE[1]);
    assign trail_edge  = sclk_edge & (sclk_s == MODE[1]);
    assign sample_edge = MODE[0] ? trail_edge : lead_edge;
    assign shift_edge  = MODE[0] ? lead_edge : trail_edge;

    state_e          state_q, state_d;
    logic [BW-1:0]   bitcnt_q, bitcnt_d;
    logic [DW-1:0]   rx_shift_q, rx_shift_d;
    logic [DW-1:0]   tx_shift_q, tx_shift_d;
    logic [DW-1:0]   tx_buf_q, tx_buf_d;
    logic            tx_ready_q, tx_ready_d;
    logic [DW-1:0]   rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            skip_q, skip_d;
    logic            word_start;
    logic [DW-1:0]   rx_next;

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_ready_d  = tx_ready_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        skip_d      = skip_q;
        word_start  = 1'b0;
        rx_next     = {rx_shift_q[DW-2:0], mosi_s};

        case (state_q)
            ST_WAIT_IDLE: begin
                if (cs_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    bitcnt_d   = '0;
                    word_start = 1'b1;
                    skip_d     = MODE[0];
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        if (bitcnt_q == LAST) begin
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            bitcnt_d   = '0;
                            word_start = 1'b1;
                            // Next shift edge belongs to the freshly loaded word's MSB
                            skip_d     = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q + BW'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (skip_q) skip_d = 1'b0;
                        else        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        if (word_start) begin
            if (!tx_ready_q) begin
                tx_shift_d = tx_buf_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d = '0;
            end
        end

        // Load is judged after any consumption in the same cycle
        if (tx_load && tx_ready_d) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync_q <= '0;
            state_q     <= ST_WAIT_IDLE;
            bitcnt_q    <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            skip_q      <= skip_d;
        end
    end

    assign MISO      = (state_q == ST_ACTIVE) & tx_shift_q[DW-1];
    assign busy      = (state_q == ST_ACTIVE);
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign state_dbg = state_q;

endmodule
